arm_operand_shifter: RTL and testbench
======================================

Name: arm_operand_shifter

Overview:
- Sequential ARM data-processing operand-2 shifter.
- Consumes the shift-source selection produced upstream (`sel`: rotate immediate / shift immediate / shift by register) plus the operand.
- Produces `shifter_operand` and `shifter_carry_out` through valid/ready handshakes.
- Iterative, one bit per cycle, to keep the execute stage small; it sits between decode/operand fetch and the ALU.

Parameters:
- CNT_W, 6, width of the internal remaining-shift counter; must hold 0..33.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- sel  in  2  shift source: 00 rotate_imm, 01 shift_imm, 10 shift by Rs, 11 reserved
- shift_type  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR; ignored for sel=00
- rotate_imm  in  4  immediate rotate field
- imm8  in  8  8-bit immediate, used when sel=00
- shift_imm  in  5  immediate shift amount
- rs  in  8  Rs[7:0]
- rm  in  32  operand register value
- carry_in  in  1  CPSR C flag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  32  shifter_operand
- carry_out  out  1  shifter_carry_out

Behaviour:
- States:
  - IDLE: `in_ready`=1.
  - SHIFT: busy.
  - DONE: `out_valid`=1.
- Reset: state IDLE; `result`=0, `carry_out`=0, `out_valid`=0, `in_ready`=1. Asserting reset mid-SHIFT or mid-DONE discards the operation.
- Accept occurs on `in_valid && in_ready`. The inputs are latched and the effective count N is computed at that edge.
- Preload rules by `sel`:
  - sel=00: value = zero-extended `imm8`, ROR, N = 2·`rotate_imm`. Carry = `carry_in` if `rotate_imm`=0, else the last bit out (= `result[31]`).
  - sel=01, LSL: N = `shift_imm`.
  - sel=01, LSR/ASR: N = `shift_imm`, except `shift_imm`=0 means N=32.
  - sel=01, ROR: N = `shift_imm`, except `shift_imm`=0 means RRX, N=1. RRX shifts `carry_in` into bit31; carry = `rm[0]`.
  - sel=10, `rs`=0: pass `rm` through, carry = `carry_in`, N=0.
  - sel=10, LSL/LSR with `rs`≥33: N clamped to 33, giving result 0, carry 0. With `rs`=32: result 0, carry = `rm[0]` (LSL) or `rm[31]` (LSR).
  - sel=10, ASR with `rs`≥32: N clamped to 32, giving result = sign fill, carry = sign.
  - sel=10, ROR: N = `rs[4:0]`. If `rs[4:0]`=0 and `rs`≠0, N=0 and carry = `rm[31]`.
  - sel=11: pass `rm`, carry = `carry_in`, N=0.
- SHIFT: each edge shifts the working value one bit per `shift_type` and loads carry with the bit shifted out (ROR: bit rotated into [31]), then decrements the counter. When the counter reaches 0, go to DONE.
- Latency: accept at edge k → `out_valid` high after edge k+1+N. N=0 gives 1 cycle.
- DONE: `result`/`carry_out` are held stable while `out_ready`=0. `out_valid && out_ready` → IDLE.
- `in_ready`=1 only in IDLE; no request is accepted in the same cycle as DONE→IDLE.
- `result`/`carry_out` change only when entering DONE.

Optional Feature:
- SHIFTER_STEP4_EN defined:
  - SHIFT consumes min(4, remaining) bits per edge.
  - Carry = last bit shifted out of that step.
  - Latency: accept edge k → `out_valid` after edge k+1+ceil(N/4).
- Undefined: one bit per edge as above.
- Results and carries are identical in both builds.

Decomposition:
- Shared package `arm_shift_pkg`:
  - shift_type encodings (LSL/LSR/ASR/ROR)
  - sel encodings (SEL_ROT_IMM, SEL_SHIFT_IMM, SEL_SHIFT_REG)
  - FSM state encoding
  - constants 32 and 33
- One sub-module, `shift_preload`: combinational decode of sel/shift_type/amounts into working value, N, initial carry and RRX flag.
- The top module holds the FSM and the shift datapath.

Test Plan:
- Rotate immediate: sel=00, imm8=0xFF, rotate_imm=4 → result 0xFF000000, carry_out 1, `out_valid` 9 cycles after accept (1-bit build).
- LSR immediate #0: sel=01, LSR, shift_imm=0, rm=0x80000001 → result 0x00000000, carry_out 1, latency 33.
- LSL by register: sel=10, LSL, rm=0xFFFFFFFF:
  - rs=33 → result 0, carry 0.
  - rs=32 → result 0, carry 1.
  - rs=0, carry_in=0 → result 0xFFFFFFFF, carry 0, latency 1.
- RRX and register ROR: sel=01, ROR, shift_imm=0, rm=0x00000003, carry_in=1 → result 0x80000001, carry 1. Then sel=10, ROR, rs=0x20, rm=0x80000000 → result 0x80000000, carry 1.
- ASR and backpressure: sel=10, ASR, rs=200, rm=0x80000000 → result 0xFFFFFFFF, carry 1. Hold out_ready=0 for 5 cycles → result stable, in_ready=0, second in_valid not accepted until after the handshake.
- Reset mid-shift: drop rst_n during SHIFT → out_valid=0, result=0, in_ready=1 immediately (asynchronous). After release, a fresh request completes correctly.

Source files
------------

// File: rtl/arm_shift_pkg.sv
// Shared definitions for the ARM operand-2 shifter: shift/select encodings,
// FSM state encoding, shift-amount constants and a single-bit shift step.
package arm_shift_pkg;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_t;

  typedef enum logic [1:0] {
    SEL_ROT_IMM   = 2'b00,
    SEL_SHIFT_IMM = 2'b01,
    SEL_SHIFT_REG = 2'b10,
    SEL_RESERVED  = 2'b11
  } sel_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  localparam int SHIFT_32 = 32;
  localparam int SHIFT_33 = 33;

  // One bit of shifting; returns {bit shifted out, new value}.
  // For ROR the carry is the bit rotated into [31]; RRX feeds the carry into [31].
  function automatic logic [32:0] shift_one(input logic [31:0] val, input logic carry,
                                            input shift_t st, input logic rrx);
    logic [32:0] r;
    case (st)
      SH_LSL:  r = {val[31], val[30:0], 1'b0};
      SH_LSR:  r = {val[0], 1'b0, val[31:1]};
      SH_ASR:  r = {val[0], val[31], val[31:1]};
      default: r = rrx ? {val[0], carry, val[31:1]} : {val[0], val[0], val[31:1]};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/shift_preload.sv
// Combinational decode of the operand-2 source into the working value, the
// effective shift count N, the initial carry and the RRX flag.
module shift_preload
  import arm_shift_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic [1:0]       i_sel,
  input  logic [1:0]       i_shift_type,
  input  logic [3:0]       i_rotate_imm,
  input  logic [7:0]       i_imm8,
  input  logic [4:0]       i_shift_imm,
  input  logic [7:0]       i_rs,
  input  logic [31:0]      i_rm,
  input  logic             i_carry_in,
  output logic [31:0]      o_value,
  output logic [CNT_W-1:0] o_count,
  output logic             o_carry,
  output shift_t           o_type,
  output logic             o_rrx
);

  shift_t w_type;
  assign w_type = shift_t'(i_shift_type);

  // Select working value / count / carry; clamped counts let the plain
  // bit-serial shifter produce the architecturally defined large-shift results.
  always_comb begin
    o_value = i_rm;
    o_count = '0;
    o_carry = i_carry_in;
    o_type  = w_type;
    o_rrx   = 1'b0;
    case (sel_t'(i_sel))
      SEL_ROT_IMM: begin
        o_value = {24'd0, i_imm8};
        o_type  = SH_ROR;
        o_count = CNT_W'({i_rotate_imm, 1'b0});
      end
      SEL_SHIFT_IMM: begin
        o_count = CNT_W'(i_shift_imm);
        if (i_shift_imm == 5'd0) begin
          case (w_type)
            SH_LSR, SH_ASR: o_count = CNT_W'(SHIFT_32);
            SH_ROR: begin
              o_count = CNT_W'(1);
              o_rrx   = 1'b1;
            end
            default: o_count = '0;
          endcase
        end
      end
      SEL_SHIFT_REG: begin
        if (i_rs != 8'd0) begin
          case (w_type)
            SH_LSL, SH_LSR:
              o_count = (i_rs >= 8'(SHIFT_33)) ? CNT_W'(SHIFT_33) : CNT_W'(i_rs);
            SH_ASR:
              o_count = (i_rs >= 8'(SHIFT_32)) ? CNT_W'(SHIFT_32) : CNT_W'(i_rs);
            default: begin
              o_count = CNT_W'(i_rs[4:0]);
              if (i_rs[4:0] == 5'd0) o_carry = i_rm[31];
            end
          endcase
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/arm_operand_shifter.sv
// Iterative ARM data-processing operand-2 shifter with valid/ready handshakes.
// Build option: SHIFTER_STEP4_EN consumes up to 4 shift bits per cycle instead of 1.
module arm_operand_shifter
  import arm_shift_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  sel,
  input  logic [1:0]  shift_type,
  input  logic [3:0]  rotate_imm,
  input  logic [7:0]  imm8,
  input  logic [4:0]  shift_imm,
  input  logic [7:0]  rs,
  input  logic [31:0] rm,
  input  logic        carry_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        carry_out
);

`ifdef SHIFTER_STEP4_EN
  localparam int STEP_BITS = 4;
`else
  localparam int STEP_BITS = 1;
`endif

  state_t           r_state, w_state_next;
  logic [31:0]      r_work, r_result;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry, r_carry_out, r_rrx;
  shift_t           r_type;

  logic [31:0]      w_pre_value, w_step_val;
  logic [CNT_W-1:0] w_pre_count, w_step_cnt;
  logic             w_pre_carry, w_pre_rrx, w_step_carry, w_accept;
  shift_t           w_pre_type;

  assign w_accept = in_valid && (r_state == ST_IDLE);

  shift_preload #(.CNT_W(CNT_W)) u_preload (
    .i_sel        (sel),
    .i_shift_type (shift_type),
    .i_rotate_imm (rotate_imm),
    .i_imm8       (imm8),
    .i_shift_imm  (shift_imm),
    .i_rs         (rs),
    .i_rm         (rm),
    .i_carry_in   (carry_in),
    .o_value      (w_pre_value),
    .o_count      (w_pre_count),
    .o_carry      (w_pre_carry),
    .o_type       (w_pre_type),
    .o_rrx        (w_pre_rrx)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic: an empty counter in SHIFT means the value is final
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (in_valid)           w_state_next = ST_SHIFT;
      ST_SHIFT: if (r_cnt == '0)        w_state_next = ST_DONE;
      ST_DONE:  if (out_ready)          w_state_next = ST_IDLE;
      default:                          w_state_next = ST_IDLE;
    endcase
  end

  // Output decode from state
  always_comb begin
    in_ready  = (r_state == ST_IDLE);
    out_valid = (r_state == ST_DONE);
  end

  // One cycle's worth of shifting: up to STEP_BITS single-bit steps, never past zero
  always_comb begin
    w_step_val   = r_work;
    w_step_carry = r_carry;
    w_step_cnt   = r_cnt;
    for (int k = 0; k < STEP_BITS; k++) begin
      if (w_step_cnt != '0) begin
        {w_step_carry, w_step_val} = shift_one(w_step_val, w_step_carry, r_type, r_rrx);
        w_step_cnt = w_step_cnt - CNT_W'(1);
      end
    end
  end

  // Datapath: latch on accept, shift while counting, publish result on entering DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work      <= '0;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_rrx       <= 1'b0;
      r_type      <= SH_LSL;
      r_result    <= '0;
      r_carry_out <= 1'b0;
    end else if (w_accept) begin
      r_work  <= w_pre_value;
      r_cnt   <= w_pre_count;
      r_carry <= w_pre_carry;
      r_rrx   <= w_pre_rrx;
      r_type  <= w_pre_type;
    end else if (r_state == ST_SHIFT) begin
      if (r_cnt == '0) begin
        r_result    <= r_work;
        r_carry_out <= r_carry;
      end else begin
        r_work  <= w_step_val;
        r_carry <= w_step_carry;
        r_cnt   <= w_step_cnt;
      end
    end
  end

  assign result    = r_result;
  assign carry_out = r_carry_out;

endmodule

// File: tb/tb_arm_operand_shifter.sv
// Self-checking bench for arm_operand_shifter: directed vector table, a
// backpressure sequence, an asynchronous reset sequence and random traffic
// checked against an arithmetic reference model.
module tb_arm_operand_shifter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  sel = '0;
  logic [1:0]  shift_type = '0;
  logic [3:0]  rotate_imm = '0;
  logic [7:0]  imm8 = '0;
  logic [4:0]  shift_imm = '0;
  logic [7:0]  rs = '0;
  logic [31:0] rm = '0;
  logic        carry_in = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        carry_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  arm_operand_shifter #(.CNT_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sel        (sel),
    .shift_type (shift_type),
    .rotate_imm (rotate_imm),
    .imm8       (imm8),
    .shift_imm  (shift_imm),
    .rs         (rs),
    .rm         (rm),
    .carry_in   (carry_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .carry_out  (carry_out)
  );

  typedef struct {
    string       nm;
    logic [1:0]  sel;
    logic [1:0]  st;
    logic [3:0]  rot;
    logic [7:0]  imm8;
    logic [4:0]  simm;
    logic [7:0]  rs;
    logic [31:0] rm;
    logic        cin;
    logic [31:0] e_res;
    logic        e_c;
    int          e_n;
  } vec_t;

  function automatic vec_t mk(string nm, logic [1:0] s, logic [1:0] st, logic [3:0] rot,
                              logic [7:0] i8, logic [4:0] si, logic [7:0] r, logic [31:0] m,
                              logic ci, logic [31:0] er, logic ec, int en);
    vec_t v;
    v.nm = nm; v.sel = s; v.st = st; v.rot = rot; v.imm8 = i8; v.simm = si;
    v.rs = r; v.rm = m; v.cin = ci; v.e_res = er; v.e_c = ec; v.e_n = en;
    return v;
  endfunction

  function automatic int lat_of(int n);
`ifdef SHIFTER_STEP4_EN
    return 1 + (n + 3) / 4;
`else
    return 1 + n;
`endif
  endfunction

  // Reference model: architectural ARM shifter results from plain arithmetic
  function automatic void ref_lsl(input logic [31:0] x, input int a, input logic ci,
                                  output logic [31:0] r, output logic c);
    if (a == 0)      begin r = x;       c = ci;        end
    else if (a < 32) begin r = x << a;  c = x[32 - a]; end
    else if (a == 32) begin r = 0;      c = x[0];      end
    else             begin r = 0;       c = 1'b0;      end
  endfunction

  function automatic void ref_lsr(input logic [31:0] x, input int a, input logic ci,
                                  output logic [31:0] r, output logic c);
    if (a == 0)       begin r = x;      c = ci;        end
    else if (a < 32)  begin r = x >> a; c = x[a - 1];  end
    else if (a == 32) begin r = 0;      c = x[31];     end
    else              begin r = 0;      c = 1'b0;      end
  endfunction

  function automatic void ref_asr(input logic [31:0] x, input int a, input logic ci,
                                  output logic [31:0] r, output logic c);
    if (a == 0)      begin r = x; c = ci; end
    else if (a < 32) begin r = 32'($signed(x) >>> a); c = x[a - 1]; end
    else             begin r = {32{x[31]}}; c = x[31]; end
  endfunction

  function automatic void ref_ror(input logic [31:0] x, input int a, input logic ci,
                                  output logic [31:0] r, output logic c);
    if (a == 0) begin r = x; c = ci; end
    else begin
      r = (x >> a) | (x << (32 - a));
      c = r[31];
    end
  endfunction

  function automatic void model(input vec_t v, output logic [31:0] r, output logic c,
                                output int n);
    int a;
    r = v.rm; c = v.cin; n = 0;
    case (v.sel)
      2'b00: begin
        a = 2 * int'(v.rot);
        ref_ror({24'd0, v.imm8}, a, v.cin, r, c);
        n = a;
      end
      2'b01: begin
        a = int'(v.simm);
        case (v.st)
          2'b00: begin ref_lsl(v.rm, a, v.cin, r, c); n = a; end
          2'b01: begin if (a == 0) a = 32; ref_lsr(v.rm, a, v.cin, r, c); n = a; end
          2'b10: begin if (a == 0) a = 32; ref_asr(v.rm, a, v.cin, r, c); n = a; end
          default: begin
            if (a == 0) begin r = {v.cin, v.rm[31:1]}; c = v.rm[0]; n = 1; end
            else begin ref_ror(v.rm, a, v.cin, r, c); n = a; end
          end
        endcase
      end
      2'b10: begin
        a = int'(v.rs);
        if (a != 0) begin
          case (v.st)
            2'b00: begin ref_lsl(v.rm, a, v.cin, r, c); n = (a > 33) ? 33 : a; end
            2'b01: begin ref_lsr(v.rm, a, v.cin, r, c); n = (a > 33) ? 33 : a; end
            2'b10: begin ref_asr(v.rm, a, v.cin, r, c); n = (a > 32) ? 32 : a; end
            default: begin
              a = a % 32;
              if (a == 0) begin r = v.rm; c = v.rm[31]; n = 0; end
              else begin ref_ror(v.rm, a, v.cin, r, c); n = a; end
            end
          endcase
        end
      end
      default: ;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    sel = v.sel; shift_type = v.st; rotate_imm = v.rot; imm8 = v.imm8;
    shift_imm = v.simm; rs = v.rs; rm = v.rm; carry_in = v.cin;
  endtask

  // One request/response; hold = cycles of out_ready=0 after out_valid rises,
  // during which a competing request is presented and must be refused.
  task automatic run_txn(input vec_t v, input int hold);
    int cyc;
    @(negedge clk);
    chk({v.nm, ".in_ready"}, 32'(in_ready), 32'd1);
    drive(v);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({v.nm, ".latency"}, 32'(cyc), 32'(lat_of(v.e_n)));
    chk({v.nm, ".result"}, result, v.e_res);
    chk({v.nm, ".carry"}, 32'(carry_out), 32'(v.e_c));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      rm = $urandom; sel = 2'b11; carry_in = ~v.e_c;
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk({v.nm, ".hold_valid"}, 32'(out_valid), 32'd1);
      chk({v.nm, ".hold_ready"}, 32'(in_ready), 32'd0);
      chk({v.nm, ".hold_result"}, result, v.e_res);
      chk({v.nm, ".hold_carry"}, 32'(carry_out), 32'(v.e_c));
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({v.nm, ".release_valid"}, 32'(out_valid), 32'd0);
    chk({v.nm, ".release_ready"}, 32'(in_ready), 32'd1);
    $display("[TB] txn %s sel=%0d type=%0d rm=%h -> result=%h carry=%0d latency=%0d",
             v.nm, v.sel, v.st, v.rm, result, carry_out, cyc);
  endtask

  vec_t tbl[11];
  vec_t v;
  logic [31:0] m_res;
  logic        m_c;
  int          m_n;

  initial begin
    tbl[0]  = mk("rot_imm",   2'b00, 2'b00, 4'd4, 8'hFF, 5'd0, 8'd0,   32'h0,        1'b0, 32'hFF000000, 1'b1, 8);
    tbl[1]  = mk("lsr_imm0",  2'b01, 2'b01, 4'd0, 8'h00, 5'd0, 8'd0,   32'h80000001, 1'b0, 32'h00000000, 1'b1, 32);
    tbl[2]  = mk("lsl_rs33",  2'b10, 2'b00, 4'd0, 8'h00, 5'd0, 8'd33,  32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b0, 33);
    tbl[3]  = mk("lsl_rs32",  2'b10, 2'b00, 4'd0, 8'h00, 5'd0, 8'd32,  32'hFFFFFFFF, 1'b0, 32'h00000000, 1'b1, 32);
    tbl[4]  = mk("lsl_rs0",   2'b10, 2'b00, 4'd0, 8'h00, 5'd0, 8'd0,   32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b0, 0);
    tbl[5]  = mk("rrx",       2'b01, 2'b11, 4'd0, 8'h00, 5'd0, 8'd0,   32'h00000003, 1'b1, 32'h80000001, 1'b1, 1);
    tbl[6]  = mk("ror_rs32",  2'b10, 2'b11, 4'd0, 8'h00, 5'd0, 8'h20,  32'h80000000, 1'b0, 32'h80000000, 1'b1, 0);
    tbl[7]  = mk("reserved",  2'b11, 2'b01, 4'd0, 8'h00, 5'd3, 8'd5,   32'h12345678, 1'b1, 32'h12345678, 1'b1, 0);
    tbl[8]  = mk("rot_imm0",  2'b00, 2'b10, 4'd0, 8'h81, 5'd0, 8'd0,   32'hFFFFFFFF, 1'b1, 32'h00000081, 1'b1, 0);
    tbl[9]  = mk("lsl_imm0",  2'b01, 2'b00, 4'd0, 8'h00, 5'd0, 8'd0,   32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0, 0);
    tbl[10] = mk("asr_imm0",  2'b01, 2'b10, 4'd0, 8'h00, 5'd0, 8'd0,   32'h7FFFFFFF, 1'b1, 32'h00000000, 1'b0, 32);

    // Reset state, sampled while reset is held across clock edges
    repeat (2) @(posedge clk);
    #1;
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    chk("reset.result", result, 32'd0);
    chk("reset.carry", 32'(carry_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) run_txn(tbl[i], 0);

    // ASR by a large register amount under 5 cycles of backpressure
    v = mk("asr_rs200_bp", 2'b10, 2'b10, 4'd0, 8'h00, 5'd0, 8'd200, 32'h80000000, 1'b0,
           32'hFFFFFFFF, 1'b1, 32);
    run_txn(v, 5);

    // Asynchronous reset while shifting discards the operation immediately
    @(negedge clk);
    drive(tbl[1]);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midreset.out_valid", 32'(out_valid), 32'd0);
    chk("midreset.in_ready", 32'(in_ready), 32'd1);
    chk("midreset.result", result, 32'd0);
    chk("midreset.carry", 32'(carry_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    v = tbl[0];
    v.nm = "after_reset";
    run_txn(v, 0);

    // Random traffic against the reference model
    for (int i = 0; i < 200; i++) begin
      v.nm   = $sformatf("rand%0d", i);
      v.sel  = 2'($urandom_range(0, 3));
      v.st   = 2'($urandom);
      v.rot  = 4'($urandom);
      v.imm8 = 8'($urandom);
      v.simm = 5'($urandom);
      case ($urandom_range(0, 3))
        0:       v.rs = 8'($urandom_range(0, 1));
        1:       v.rs = 8'($urandom_range(0, 40));
        2:       v.rs = {3'($urandom), 5'd0};
        default: v.rs = 8'($urandom);
      endcase
      v.rm  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : 32'($urandom);
      v.cin = 1'($urandom);
      model(v, m_res, m_c, m_n);
      v.e_res = m_res;
      v.e_c   = m_c;
      v.e_n   = m_n;
      run_txn(v, $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
